seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_scan_driver.sv | 117 +++++++++++
 tb/tb_seg7_scan_driver.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for a 4-digit common-anode
// 7-segment display.
// - Each digit stays lit for REFRESH_DIV clocks.
// - A shadow copy of display_in is taken once per frame, so a frame always
//   shows one coherent value.
// - Optional macro LEADING_ZERO_BLANK_EN darkens leading zero digits 3..1.
//   Digit 0 is never darkened by this rule.
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] display_in,
    input  logic [3:0]  dp_in,
    input  logic        blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [15:0]      shadow;

    logic             tick_c;
    logic             load_c;
    logic [3:0]       nibble_c;
    logic [6:0]       seg_c;
    logic             suppress_c;

    assign tick_c = (cnt == CNT_MAX);
    assign load_c = tick_c && (idx == 2'd3);

    // Refresh counter, digit index and per-frame shadow capture
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= 2'd0;
            shadow      <= 16'h0000;
            frame_start <= 1'b0;
        end else begin
            cnt         <= tick_c ? '0 : cnt + CNT_W'(1);
            frame_start <= load_c;
            if (tick_c) begin
                idx <= idx + 2'd1;
            end
            if (load_c) begin
                shadow <= display_in;
            end
        end
    end

    // Select the nibble and leading-zero status for the current digit
    always_comb begin
        nibble_c   = shadow[3:0];
        suppress_c = 1'b0;
        case (idx)
            2'd0: nibble_c = shadow[3:0];
            2'd1: nibble_c = shadow[7:4];
            2'd2: nibble_c = shadow[11:8];
            2'd3: nibble_c = shadow[15:12];
            default: nibble_c = shadow[3:0];
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        case (idx)
            2'd1: suppress_c = (shadow[15:4] == 12'h000);
            2'd2: suppress_c = (shadow[15:8] == 8'h00);
            2'd3: suppress_c = (shadow[15:12] == 4'h0);
            default: suppress_c = 1'b0;
        endcase
`else
        suppress_c = 1'b0;
`endif
    end

    // Hex to active-low segment pattern {g,f,e,d,c,b,a}
    always_comb begin
        seg_c = 7'h7F;
        case (nibble_c)
            4'h0: seg_c = 7'h40;
            4'h1: seg_c = 7'h79;
            4'h2: seg_c = 7'h24;
            4'h3: seg_c = 7'h30;
            4'h4: seg_c = 7'h19;
            4'h5: seg_c = 7'h12;
            4'h6: seg_c = 7'h02;
            4'h7: seg_c = 7'h78;
            4'h8: seg_c = 7'h00;
            4'h9: seg_c = 7'h10;
            4'hA: seg_c = 7'h08;
            4'hB: seg_c = 7'h03;
            4'hC: seg_c = 7'h46;
            4'hD: seg_c = 7'h21;
            4'hE: seg_c = 7'h06;
            4'hF: seg_c = 7'h0E;
            default: seg_c = 7'h7F;
        endcase
    end

    // Registered display outputs, dark during reset, blank or suppression
    always_ff @(posedge clk) begin
        if (rst || blank || suppress_c) begin
            an  <= 4'b1111;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= seg_c;
            dp  <= ~dp_in[idx];
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=4.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_seg7_scan_driver;

    localparam int unsigned DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] display_in;
    logic [3:0]  dp_in;
    logic        blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    int tests_run = 0;
    int fails     = 0;

    logic [3:0] an_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    seg7_scan_driver #(.REFRESH_DIV(DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .display_in  (display_in),
        .dp_in       (dp_in),
        .blank       (blank),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(negedge clk);
    endtask

    // Reset values, then the first frame which shows the zero shadow
    task automatic test_reset;
        logic [12:0] got, exp;
        logic [6:0]  s_tab [4];
        logic [3:0]  a_tab [4];
        rst = 1'b1; display_in = 16'h1234; dp_in = 4'h0; blank = 1'b0;
        repeat (3) step();
        got = {an, seg, dp, frame_start};
        exp = {4'hF, 7'h7F, 1'b1, 1'b0};
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("FAIL reset_state: got %h want %h", got, exp);
        end
        s_tab = '{7'h40, 7'h40, 7'h40, 7'h40};
        a_tab = an_tab;
`ifdef LEADING_ZERO_BLANK_EN
        s_tab = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
        a_tab = '{4'hE, 4'hF, 4'hF, 4'hF};
`endif
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            got = {an, seg, dp, frame_start};
            exp = {a_tab[i/4], s_tab[i/4], 1'b1, (i == 15)};
            tests_run++;
            if (got !== exp) begin
                fails++;
                $display("FAIL first_frame[%0d]: got %h want %h", i, got, exp);
            end
        end
    endtask

    // Second frame shows 1234, with decimal points on digits 0 and 2
    task automatic test_frame2;
        logic [12:0] got, exp;
        logic [6:0]  s_tab [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
        logic        d_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        dp_in = 4'b0101;
        for (int i = 0; i < 16; i++) begin
            step();
            got = {an, seg, dp, frame_start};
            exp = {an_tab[i/4], s_tab[i/4], d_tab[i/4], (i == 15)};
            tests_run++;
            if (got !== exp) begin
                fails++;
                $display("FAIL frame2[%0d]: got %h want %h", i, got, exp);
            end
        end
    endtask

    // display_in change mid-frame only takes effect after the next load
    task automatic test_midframe_change;
        logic [12:0] got, exp;
        logic [6:0]  s_tab [8] = '{7'h19, 7'h30, 7'h24, 7'h79,
                                   7'h21, 7'h46, 7'h03, 7'h08};
        logic        d_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 32; i++) begin
            step();
            if (i == 5) display_in = 16'hABCD;
            got = {an, seg, dp, frame_start};
            exp = {an_tab[(i/4)%4], s_tab[i/4], d_tab[(i/4)%4], ((i % 16) == 15)};
            tests_run++;
            if (got !== exp) begin
                fails++;
                $display("FAIL midframe[%0d]: got %h want %h", i, got, exp);
            end
        end
    endtask

    // Blank darkens outputs while scanning and shadow loading continue
    task automatic test_blank;
        logic [12:0] got, exp;
        logic [6:0]  s_pre [5] = '{7'h21, 7'h21, 7'h21, 7'h21, 7'h46};
        logic [3:0]  a_pre [5] = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hD};
        dp_in = 4'h0;
        for (int i = 0; i < 5; i++) begin
            step();
            got = {an, seg, dp, frame_start};
            exp = {a_pre[i], s_pre[i], 1'b1, 1'b0};
            tests_run++;
            if (got !== exp) begin
                fails++;
                $display("FAIL pre_blank[%0d]: got %h want %h", i, got, exp);
            end
        end
        blank = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            got = {an, seg, dp, frame_start};
            exp = {4'hF, 7'h7F, 1'b1, 1'b0};
            tests_run++;
            if (got !== exp) begin
                fails++;
                $display("FAIL blanked[%0d]: got %h want %h", i, got, exp);
            end
        end
        blank = 1'b0;
        step();
        got = {an, seg, dp, frame_start};
        exp = {4'h7, 7'h08, 1'b1, 1'b1};
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("FAIL unblank_digit3: got %h want %h", got, exp);
        end
        step();
        got = {an, seg, dp, frame_start};
        exp = {4'hE, 7'h21, 1'b1, 1'b0};
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("FAIL unblank_digit0: got %h want %h", got, exp);
        end
    endtask

    // Reset during digit 2 aborts the frame and restarts at digit 0
    task automatic test_reset_mid;
        logic [12:0] got, exp;
        logic [6:0]  s_tab [4];
        logic [3:0]  a_tab [4];
        repeat (9) step();
        got = {an, seg, dp, frame_start};
        exp = {4'hB, 7'h03, 1'b1, 1'b0};
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("FAIL before_rst_digit2: got %h want %h", got, exp);
        end
        rst = 1'b1;
        step();
        got = {an, seg, dp, frame_start};
        exp = {4'hF, 7'h7F, 1'b1, 1'b0};
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("FAIL mid_reset_dark: got %h want %h", got, exp);
        end
        rst = 1'b0;
        s_tab = '{7'h40, 7'h40, 7'h40, 7'h40};
        a_tab = an_tab;
`ifdef LEADING_ZERO_BLANK_EN
        s_tab = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
        a_tab = '{4'hE, 4'hF, 4'hF, 4'hF};
`endif
        for (int i = 0; i < 16; i++) begin
            step();
            got = {an, seg, dp, frame_start};
            exp = {a_tab[i/4], s_tab[i/4], 1'b1, (i == 15)};
            tests_run++;
            if (got !== exp) begin
                fails++;
                $display("FAIL after_mid_reset[%0d]: got %h want %h", i, got, exp);
            end
        end
        step();
        got = {an, seg, dp, frame_start};
        exp = {4'hE, 7'h21, 1'b1, 1'b0};
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("FAIL reload_after_reset: got %h want %h", got, exp);
        end
    endtask

    // Leading-zero values 0050 and 0000, expectations depend on the macro
    task automatic test_leading_zero;
        logic [12:0] got, exp;
        logic [6:0]  s_tab [8];
        logic [3:0]  a_tab [8];
        s_tab = '{7'h40, 7'h12, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        a_tab = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE, 4'hD, 4'hB, 4'h7};
`ifdef LEADING_ZERO_BLANK_EN
        s_tab = '{7'h40, 7'h12, 7'h7F, 7'h7F, 7'h40, 7'h7F, 7'h7F, 7'h7F};
        a_tab = '{4'hE, 4'hD, 4'hF, 4'hF, 4'hE, 4'hF, 4'hF, 4'hF};
`endif
        display_in = 16'h0050;
        repeat (15) step();
        tests_run++;
        if (frame_start !== 1'b1) begin
            fails++;
            $display("FAIL lz_load_pulse: got %b want 1", frame_start);
        end
        for (int i = 0; i < 32; i++) begin
            step();
            if (i == 2) display_in = 16'h0000;
            got = {an, seg, dp, frame_start};
            exp = {a_tab[i/4], s_tab[i/4], 1'b1, ((i % 16) == 15)};
            tests_run++;
            if (got !== exp) begin
                fails++;
                $display("FAIL leading_zero[%0d]: got %h want %h", i, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame2();
        test_midframe_change();
        test_blank();
        test_reset_mid();
        test_leading_zero();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
